mem_stage_pipe: RTL and testbench

Parametrised memory-access stage for the five-stage in-order pipeline, sitting between the execute and writeback stages. It waits for a variable-latency, in-order data-memory response and extracts the loaded byte, half or word with sign or zero extension. It selects the final result, tracks responses owed to cancelled loads so they are discarded, and optionally drives an ID-stage bypass.

---
 rtl/mem_stage_pipe_pkg.sv | 23 ++
 rtl/mem_stage_pipe_load_extract.sv | 33 +++
 rtl/mem_stage_pipe.sv | 130 +++++++++++++
 tb/tb_mem_stage_pipe.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pipe_pkg.sv
// Shared definitions for the memory-access stage: load-op encodings, stage
// states and the byte-offset width derived from the datapath width.
package mem_stage_pipe_pkg;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LD  = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;
    localparam logic [2:0] LOAD_LWU = 3'b110;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_WAIT_RESP = 2'd1,
        ST_DONE      = 2'd2
    } ms_state_e;

    function automatic int offset_width(input int xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/mem_stage_pipe_load_extract.sv
// Combinational load aligner: shifts the response down by the byte offset and
// sign- or zero-extends the selected byte/half/word/double to XLEN.
module load_extract
    import mem_stage_pipe_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int OFFW = offset_width(XLEN)
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [OFFW-1:0] i_offset,
    input  logic [2:0]      i_op,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_result = w_shifted;
        case (i_op)
            LOAD_LB:  o_result = XLEN'($signed(w_shifted[7:0]));
            LOAD_LH:  o_result = XLEN'($signed(w_shifted[15:0]));
            LOAD_LW:  o_result = XLEN'($signed(w_shifted[31:0]));
            LOAD_LD:  o_result = w_shifted;
            LOAD_LBU: o_result = XLEN'(w_shifted[7:0]);
            LOAD_LHU: o_result = XLEN'(w_shifted[15:0]);
            LOAD_LWU: o_result = XLEN'(w_shifted[31:0]);
            default:  o_result = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// Memory-access pipeline stage: waits for in-order data responses, drops those
// owed to cancelled loads, extracts load data. MS_FWD_EN enables the ID bypass.
module mem_stage_pipe
    import mem_stage_pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MAX_DISCARD = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            es_to_ms_valid,
    output logic            ms_allowin,
    input  logic [31:0]     es_pc,
    input  logic            es_res_from_mem,
    input  logic [2:0]      es_load_op,
    input  logic [XLEN-1:0] es_alu_result,
    input  logic [4:0]      es_dest,
    input  logic            es_gr_we,
    input  logic            es_cancel_req,
    input  logic            data_rvalid,
    input  logic [XLEN-1:0] data_rdata,
    input  logic            ms_flush,
    input  logic            ws_allowin,
    output logic            ms_to_ws_valid,
    output logic [31:0]     ms_pc,
    output logic [XLEN-1:0] ms_final_result,
    output logic [4:0]      ms_dest,
    output logic            ms_gr_we,
    output logic            ms_fwd_valid,
    output logic            ms_fwd_ready,
    output logic [4:0]      ms_fwd_dest,
    output logic [XLEN-1:0] ms_fwd_data
);

    localparam int OFFW = offset_width(XLEN);
    localparam int CW   = $clog2(MAX_DISCARD + 1);

    ms_state_e       r_state;
    logic [CW-1:0]   r_discard_cnt;
    logic [31:0]     r_pc;
    logic [2:0]      r_load_op;
    logic [OFFW-1:0] r_offset;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_dest;
    logic            r_gr_we;

    logic            w_cnt_zero;
    logic            w_consume;
    logic            w_ready_go;
    logic            w_accept;
    logic            w_flush_owed;
    logic            w_drop;
    logic [CW:0]     w_cnt_sum;
    logic [XLEN-1:0] w_load_data;

    assign w_cnt_zero = (r_discard_cnt == '0);
    assign w_consume  = (r_state == ST_WAIT_RESP) && data_rvalid && w_cnt_zero;
    assign w_ready_go = (r_state == ST_DONE) || w_consume;
    assign ms_allowin = !ms_flush && ((r_state == ST_EMPTY) || (w_ready_go && ws_allowin));
    assign w_accept   = es_to_ms_valid && ms_allowin;

    // A flushed load still has its response in flight unless it lands this cycle.
    assign w_flush_owed = ms_flush && (r_state == ST_WAIT_RESP) && !w_consume;
    assign w_drop       = data_rvalid && !w_cnt_zero;
    assign w_cnt_sum    = {1'b0, r_discard_cnt} + (CW+1)'(es_cancel_req)
                        + (CW+1)'(w_flush_owed) - (CW+1)'(w_drop);

    load_extract #(.XLEN(XLEN)) u_extract (
        .i_rdata  (data_rdata),
        .i_offset (r_offset),
        .i_op     (r_load_op),
        .o_result (w_load_data)
    );

    assign ms_to_ws_valid  = w_ready_go && !ms_flush;
    assign ms_final_result = w_consume ? w_load_data : r_result;
    assign ms_pc           = r_pc;
    assign ms_dest         = r_dest;
    assign ms_gr_we        = r_gr_we;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_EMPTY;
            r_discard_cnt <= '0;
            r_pc          <= '0;
            r_load_op     <= '0;
            r_offset      <= '0;
            r_result      <= '0;
            r_dest        <= '0;
            r_gr_we       <= 1'b0;
        end else begin
            r_discard_cnt <= w_cnt_sum[CW-1:0];
            if (ms_flush) begin
                r_state <= ST_EMPTY;
            end else if (w_accept) begin
                r_state   <= es_res_from_mem ? ST_WAIT_RESP : ST_DONE;
                r_pc      <= es_pc;
                r_load_op <= es_load_op;
                r_offset  <= es_alu_result[OFFW-1:0];
                r_result  <= es_alu_result;
                r_dest    <= es_dest;
                r_gr_we   <= es_gr_we;
            end else if (w_ready_go && ws_allowin) begin
                r_state <= ST_EMPTY;
            end else if (w_consume) begin
                r_state  <= ST_DONE;
                r_result <= w_load_data;
            end
        end
    end

`ifdef MS_FWD_EN
    assign ms_fwd_valid = ((r_state == ST_WAIT_RESP) || (r_state == ST_DONE)) && r_gr_we;
    assign ms_fwd_ready = w_ready_go;
    assign ms_fwd_dest  = r_dest;
    assign ms_fwd_data  = ms_final_result;
`else
    assign ms_fwd_valid = 1'b0;
    assign ms_fwd_ready = 1'b0;
    assign ms_fwd_dest  = '0;
    assign ms_fwd_data  = '0;
`endif

    a_discard_overflow: assert property (@(posedge clk) disable iff (!resetn)
        w_cnt_sum <= (CW+1)'(MAX_DISCARD));

    a_stray_response: assert property (@(posedge clk) disable iff (!resetn)
        !(data_rvalid && w_cnt_zero && (r_state != ST_WAIT_RESP)));

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe: a memory model returns in-order
// responses, a reference model predicts each handshake and its result.
module tb_mem_stage_pipe;

    localparam int XLEN = 32;
    localparam int MAXD = 3;

    logic            clk = 1'b0;
    logic            resetn;
    logic            es_to_ms_valid;
    logic            ms_allowin;
    logic [31:0]     es_pc;
    logic            es_res_from_mem;
    logic [2:0]      es_load_op;
    logic [XLEN-1:0] es_alu_result;
    logic [4:0]      es_dest;
    logic            es_gr_we;
    logic            es_cancel_req;
    logic            data_rvalid;
    logic [XLEN-1:0] data_rdata;
    logic            ms_flush;
    logic            ws_allowin;
    logic            ms_to_ws_valid;
    logic [31:0]     ms_pc;
    logic [XLEN-1:0] ms_final_result;
    logic [4:0]      ms_dest;
    logic            ms_gr_we;
    logic            ms_fwd_valid;
    logic            ms_fwd_ready;
    logic [4:0]      ms_fwd_dest;
    logic [XLEN-1:0] ms_fwd_data;

    mem_stage_pipe #(.XLEN(XLEN), .MAX_DISCARD(MAXD)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_allowin      (ms_allowin),
        .es_pc           (es_pc),
        .es_res_from_mem (es_res_from_mem),
        .es_load_op      (es_load_op),
        .es_alu_result   (es_alu_result),
        .es_dest         (es_dest),
        .es_gr_we        (es_gr_we),
        .es_cancel_req   (es_cancel_req),
        .data_rvalid     (data_rvalid),
        .data_rdata      (data_rdata),
        .ms_flush        (ms_flush),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_pc           (ms_pc),
        .ms_final_result (ms_final_result),
        .ms_dest         (ms_dest),
        .ms_gr_we        (ms_gr_we),
        .ms_fwd_valid    (ms_fwd_valid),
        .ms_fwd_ready    (ms_fwd_ready),
        .ms_fwd_dest     (ms_fwd_dest),
        .ms_fwd_data     (ms_fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        we;
        bit          is_load;
        bit          got_resp;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          rdy;
        bit          live;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          mem_hold = 1'b0;
    int          cancel_lat = 0;
    logic [31:0] pend_rdata;
    int          pend_lat;
    bit          pend_use_k;
    logic [31:0] pend_k;

    bit m_occ, m_live_now, m_rdy_now, m_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // Reference extraction with plain integer arithmetic.
    function automatic logic [31:0] model_load(input logic [2:0] op, input int off, input logic [31:0] rd);
        longint unsigned sh, span, val;
        int nb;
        bit sgn;
        sh = 64'(rd) / (64'd1 << (off * 8));
        case (op)
            3'd0:    begin nb = 1; sgn = 1; end
            3'd1:    begin nb = 2; sgn = 1; end
            3'd2:    begin nb = 4; sgn = 1; end
            3'd4:    begin nb = 1; sgn = 0; end
            3'd5:    begin nb = 2; sgn = 0; end
            default: begin nb = 4; sgn = 0; end
        endcase
        span = 64'd1 << (8 * nb);
        val  = sh % span;
        if (sgn && val >= span / 2) val = val + (64'h1_0000_0000 - span);
        return val[31:0];
    endfunction

    function automatic bit has_live();
        foreach (mem_q[i]) if (mem_q[i].live) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_mem(input logic [31:0] rd, input int lat, input bit live);
        mem_t e;
        int r;
        r = cyc + 1 + lat;
        if (mem_q.size() > 0 && mem_q[mem_q.size()-1].rdy > r) r = mem_q[mem_q.size()-1].rdy;
        e.rdata = rd;
        e.rdy   = r;
        e.live  = live;
        mem_q.push_back(e);
    endtask

    // One clock: present memory response, update the model just before the edge.
    task automatic tick(output bit acc);
        mem_t m;
        exp_t x;
        acc = 1'b0;
        if (resetn && !mem_hold && mem_q.size() > 0 && mem_q[0].rdy <= cyc) begin
            data_rvalid = 1'b1;
            data_rdata  = mem_q[0].rdata;
        end else begin
            data_rvalid = 1'b0;
            data_rdata  = $urandom;
        end
        @(negedge clk);
        #4;
        if (!resetn) begin
            exp_q.delete();
            mem_q.delete();
        end else begin
            if (data_rvalid) begin
                m = mem_q.pop_front();
                if (m.live && exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    x.got_resp = 1'b1;
                    exp_q.push_front(x);
                end
            end
            if (ms_flush) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                for (int i = 0; i < mem_q.size(); i++) begin
                    m = mem_q[i];
                    m.live = 1'b0;
                    mem_q[i] = m;
                end
            end
            if (es_cancel_req) push_mem($urandom, cancel_lat, 1'b0);
            if (es_to_ms_valid && ms_allowin && !ms_flush) begin
                acc       = 1'b1;
                x.pc      = es_pc;
                x.dest    = es_dest;
                x.we      = es_gr_we;
                x.is_load = es_res_from_mem;
                x.got_resp = 1'b0;
                if (es_res_from_mem)
                    x.result = pend_use_k ? pend_k : model_load(es_load_op, int'(es_alu_result[1:0]), pend_rdata);
                else
                    x.result = es_alu_result;
                exp_q.push_back(x);
                if (es_res_from_mem) push_mem(pend_rdata, pend_lat, 1'b1);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic issue(input bit ld, input logic [2:0] op, input logic [31:0] alu,
                         input logic [31:0] rd, input int lat, input bit use_k, input logic [31:0] k);
        bit acc;
        acc             = 1'b0;
        es_to_ms_valid  = 1'b1;
        es_res_from_mem = ld;
        es_load_op      = op;
        es_alu_result   = alu;
        es_pc           = $urandom;
        es_dest         = 5'($urandom);
        es_gr_we        = 1'b1;
        pend_rdata      = rd;
        pend_lat        = lat;
        pend_use_k      = use_k;
        pend_k          = k;
        for (int i = 0; i < 64; i++) begin
            tick(acc);
            if (acc) break;
        end
        es_to_ms_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL issue_timeout at cycle %0d: instruction not accepted, expected acceptance", cyc);
        end
    endtask

    // Monitor: compares DUT outputs with the scoreboard head, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn === 1'b1) begin
                m_occ      = exp_q.size() > 0;
                m_live_now = data_rvalid && mem_q.size() > 0 && mem_q[0].live;
                m_rdy_now  = m_occ && (!exp_q[0].is_load || exp_q[0].got_resp || m_live_now);
                m_valid    = m_rdy_now && !ms_flush;
                check("to_ws_valid", 64'(ms_to_ws_valid), 64'(m_valid));
                check("allowin", 64'(ms_allowin), 64'(!ms_flush && (!m_occ || (m_rdy_now && ws_allowin))));
                if (m_valid) begin
                    check("pc", 64'(ms_pc), 64'(exp_q[0].pc));
                    check("final_result", 64'(ms_final_result), 64'(exp_q[0].result));
                    check("dest", 64'(ms_dest), 64'(exp_q[0].dest));
                    check("gr_we", 64'(ms_gr_we), 64'(exp_q[0].we));
                end
`ifdef MS_FWD_EN
                check("fwd_valid", 64'(ms_fwd_valid), 64'(m_occ && exp_q[0].we));
                check("fwd_ready", 64'(ms_fwd_ready), 64'(m_rdy_now));
                if (m_occ && exp_q[0].we) check("fwd_dest", 64'(ms_fwd_dest), 64'(exp_q[0].dest));
                if (m_rdy_now) check("fwd_data", 64'(ms_fwd_data), 64'(exp_q[0].result));
`else
                check("fwd_tied", 64'({ms_fwd_valid, ms_fwd_ready, ms_fwd_dest, ms_fwd_data}), 64'd0);
`endif
                if (m_valid && ws_allowin) void'(exp_q.pop_front());
            end
        end
    end

    logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        bit acc;
        bit ld;
        int cnt;
        resetn          = 1'b0;
        es_to_ms_valid  = 1'b0;
        es_pc           = '0;
        es_res_from_mem = 1'b0;
        es_load_op      = '0;
        es_alu_result   = '0;
        es_dest         = '0;
        es_gr_we        = 1'b0;
        es_cancel_req   = 1'b0;
        data_rvalid     = 1'b0;
        data_rdata      = '0;
        ms_flush        = 1'b0;
        ws_allowin      = 1'b1;
        pend_use_k      = 1'b0;
        pend_k          = '0;
        pend_rdata      = '0;
        pend_lat        = 0;

        #2;
        check("rst_to_ws_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rst_allowin", 64'(ms_allowin), 64'd1);
        check("rst_pc", 64'(ms_pc), 64'd0);
        check("rst_final_result", 64'(ms_final_result), 64'd0);
        check("rst_dest_we", 64'({ms_dest, ms_gr_we}), 64'd0);
        check("rst_fwd", 64'({ms_fwd_valid, ms_fwd_ready}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);

        // Directed cases
        issue(1'b0, 3'd0, 32'h0000_1234, 32'h0, 0, 1'b1, 32'h0000_1234);
        idle(2);
        issue(1'b1, 3'd0, 32'h0000_1003, 32'h80FF_0000, 0, 1'b1, 32'hFFFF_FF80);
        idle(2);
        issue(1'b1, 3'd4, 32'h0000_1003, 32'h80FF_0000, 1, 1'b1, 32'h0000_0080);
        idle(3);
        issue(1'b1, 3'd5, 32'h0000_2002, 32'hBEEF_0000, 0, 1'b1, 32'h0000_BEEF);
        idle(2);

        ws_allowin = 1'b0;
        issue(1'b1, 3'd2, 32'h0000_0100, 32'hCAFE_F00D, 3, 1'b1, 32'hCAFE_F00D);
        idle(6);
        ws_allowin = 1'b1;
        idle(2);

        issue(1'b1, 3'd2, 32'h0000_0200, 32'h0000_AAAA, 6, 1'b0, 32'h0);
        idle(1);
        ms_flush = 1'b1;
        idle(1);
        ms_flush = 1'b0;
        issue(1'b1, 3'd2, 32'h0000_0300, 32'h0000_5555, 0, 1'b1, 32'h0000_5555);
        idle(10);

        mem_hold      = 1'b1;
        es_cancel_req = 1'b1;
        idle(1);
        es_cancel_req = 1'b0;
        idle(1);
        mem_hold      = 1'b0;
        es_cancel_req = 1'b1;
        idle(1);
        es_cancel_req = 1'b0;
        issue(1'b1, 3'd2, 32'h0000_0400, 32'h0000_7777, 0, 1'b1, 32'h0000_7777);
        idle(8);

        issue(1'b1, 3'd2, 32'h0000_0500, 32'h1111_2222, 20, 1'b0, 32'h0);
        idle(2);
        resetn = 1'b0;
        #1;
        check("midrst_to_ws_valid", 64'(ms_to_ws_valid), 64'd0);
        check("midrst_allowin", 64'(ms_allowin), 64'd1);
        check("midrst_fwd_ready", 64'(ms_fwd_ready), 64'd0);
        check("midrst_final_result", 64'(ms_final_result), 64'd0);
        idle(1);
        resetn = 1'b1;
        idle(1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!es_to_ms_valid && $urandom_range(0, 99) < 60) begin
                ld              = (mem_q.size() < MAXD) && ($urandom_range(0, 1) == 1);
                es_to_ms_valid  = 1'b1;
                es_res_from_mem = ld;
                es_load_op      = ops[$urandom_range(0, 4)];
                es_alu_result   = $urandom;
                es_pc           = $urandom;
                es_dest         = 5'($urandom);
                es_gr_we        = 1'($urandom);
                pend_rdata      = $urandom;
                pend_lat        = $urandom_range(0, 4);
                pend_use_k      = 1'b0;
            end
            ws_allowin    = ($urandom_range(0, 99) < 75);
            ms_flush      = ($urandom_range(0, 99) < 4);
            cancel_lat    = $urandom_range(0, 3);
            cnt           = mem_q.size() + ((es_to_ms_valid && es_res_from_mem) ? 1 : 0);
            es_cancel_req = ($urandom_range(0, 99) < 6) && !has_live() && (cnt < MAXD);
            tick(acc);
            if (acc) es_to_ms_valid = 1'b0;
        end

        es_to_ms_valid = 1'b0;
        es_cancel_req  = 1'b0;
        ms_flush       = 1'b0;
        ws_allowin     = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && mem_q.size() == 0) break;
            tick(acc);
        end
        check("drain_expected_left", 64'(exp_q.size()), 64'd0);
        check("drain_responses_left", 64'(mem_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
